aes_dec_arbiter: RTL and testbench

- Shares one AES decryption core between two requesters, each with valid/ready request and response channels.
- Grants requesters round-robin and latches the granted key and ciphertext.
- Sequences the core's level-sensitive start/done protocol, including the mandatory start-low release gap.
- Returns plaintext to the owning requester; a watchdog recovers the core if done never arrives.

---
 rtl/aes_ctrl_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 45 ++++
 rtl/aes_dec_arbiter.sv | 149 ++++++++++++++
 tb/tb_aes_dec_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES decryption-core arbiter: controller states,
// requester id and block width.
package aes_ctrl_pkg;

   localparam int AES_W = 128;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RESP,
      RELEASE
   } state_t;

   typedef logic             owner_t;
   typedef logic [AES_W-1:0] block_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; a tie goes to the requester that did not win
// the last accepted grant.
module rr_arbiter2
   import aes_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_grant,
   output owner_t     o_grant_id
);

   owner_t r_last;

   always_comb begin
      // NOTE: every output gets a default first, so no latch is inferred.
      o_grant    = 2'b00;
      o_grant_id = 1'b0;
      case (i_req)
         2'b01: begin
            o_grant    = 2'b01;
            o_grant_id = 1'b0;
         end
         2'b10: begin
            o_grant    = 2'b10;
            o_grant_id = 1'b1;
         end
         2'b11: begin
            o_grant_id = ~r_last;
            o_grant    = r_last ? 2'b01 : 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (i_accept) begin
         r_last <= o_grant_id;
      end
   end

endmodule

// File: rtl/aes_dec_arbiter.sv
// Shares one AES decryption core between two valid/ready requesters: grants,
// sequences the core start/done levels, returns plaintext and recovers hangs.
module aes_dec_arbiter
   import aes_ctrl_pkg::*;
#(
   parameter int TIMEOUT    = 255,
   parameter int REL_CYCLES = 2
) (
   input  logic         clk,
   input  logic         RESET_N,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [127:0] req0_key,
   input  logic [127:0] req0_msg,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [127:0] req1_key,
   input  logic [127:0] req1_msg,
   output logic         resp0_valid,
   input  logic         resp0_ready,
   output logic [127:0] resp0_data,
   output logic         resp0_err,
   output logic         resp1_valid,
   input  logic         resp1_ready,
   output logic [127:0] resp1_data,
   output logic         resp1_err,
   output logic         AES_START,
   output logic [127:0] AES_KEY,
   output logic [127:0] AES_MSG_ENC,
   input  logic         AES_DONE,
   input  logic [127:0] AES_MSG_DEC,
   output logic         AES_RESET,
   output logic         busy
);

   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam int REL_W = $clog2(REL_CYCLES + 1);

   state_t           r_state;
   owner_t           r_owner;
   block_t           r_key;
   block_t           r_msg;
   block_t           r_data;
   logic             r_err;
   logic [1:0]       r_resp_valid;
   logic             r_start;
   logic             r_aes_reset;
   logic [WD_W-1:0]  r_wdog;
   logic [REL_W-1:0] r_rel;

   logic [1:0]       w_grant;
   owner_t           w_grant_id;
   logic             w_accept;
   logic             w_resp_hs;
   logic [WD_W-1:0]  w_wdog_next;

   rr_arbiter2 u_arb (
      .clk        (clk),
      .rst_n      (RESET_N),
      .i_req      ({req1_valid, req0_valid}),
      .i_accept   (w_accept),
      .o_grant    (w_grant),
      .o_grant_id (w_grant_id)
   );

   assign w_accept    = (r_state == IDLE) && (|w_grant);
   assign w_resp_hs   = |(r_resp_valid & {resp1_ready, resp0_ready});
   assign w_wdog_next = r_wdog + 1'b1;

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_key        <= '0;
         r_msg        <= '0;
         r_data       <= '0;
         r_err        <= 1'b0;
         r_resp_valid <= 2'b00;
         r_start      <= 1'b0;
         r_aes_reset  <= 1'b1;
         r_wdog       <= '0;
         r_rel        <= '0;
      end else begin
         // Core reset is a one-cycle pulse: held over reset release, or after an abort.
         r_aes_reset <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_key   <= w_grant_id ? req1_key : req0_key;
                  r_msg   <= w_grant_id ? req1_msg : req0_msg;
                  r_owner <= w_grant_id;
                  r_wdog  <= '0;
                  r_start <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_wdog <= w_wdog_next;
               if (AES_DONE) begin
                  r_data                <= AES_MSG_DEC;
                  r_err                 <= 1'b0;
                  r_start               <= 1'b0;
                  r_resp_valid[r_owner] <= 1'b1;
                  r_state               <= RESP;
               end else if (w_wdog_next == WD_W'(TIMEOUT)) begin
                  r_data                <= '0;
                  r_err                 <= 1'b1;
                  r_aes_reset           <= 1'b1;
                  r_start               <= 1'b0;
                  r_resp_valid[r_owner] <= 1'b1;
                  r_state               <= RESP;
               end
            end
            RESP: begin
               if (w_resp_hs) begin
                  r_resp_valid <= 2'b00;
                  r_rel        <= '0;
                  r_state      <= RELEASE;
               end
            end
            RELEASE: begin
               if (r_rel == REL_W'(REL_CYCLES - 1)) begin
                  r_state <= IDLE;
               end else begin
                  r_rel <= r_rel + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req0_ready  = (r_state == IDLE) && w_grant[0];
   assign req1_ready  = (r_state == IDLE) && w_grant[1];

   assign resp0_valid = r_resp_valid[0];
   assign resp0_data  = r_resp_valid[0] ? r_data : '0;
   assign resp0_err   = r_resp_valid[0] & r_err;
   assign resp1_valid = r_resp_valid[1];
   assign resp1_data  = r_resp_valid[1] ? r_data : '0;
   assign resp1_err   = r_resp_valid[1] & r_err;

   assign AES_START   = r_start;
   assign AES_KEY     = r_key;
   assign AES_MSG_ENC = r_msg;
   assign AES_RESET   = r_aes_reset;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Scoreboard bench for aes_dec_arbiter: directed requests against a behavioural
// core stub; a monitor pops expected grants/responses as the DUT presents them.
module tb_aes_dec_arbiter;
   import aes_ctrl_pkg::*;

   localparam int TIMEOUT    = 16;
   localparam int REL_CYCLES = 2;

   localparam block_t FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam block_t FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam block_t FIPS_P = 128'h00112233445566778899aabbccddeeff;
   // Non-FIPS traffic: the stub core returns key ^ msg, precomputed below.
   localparam block_t K0 = 128'h0000_0000_0000_0000_ffff_ffff_ffff_ffff;
   localparam block_t M0 = 128'h1234_5678_9abc_def0_1234_5678_9abc_def0;
   localparam block_t E0 = 128'h1234_5678_9abc_def0_edcb_a987_6543_210f;
   localparam block_t K1 = 128'haaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa;
   localparam block_t M1 = 128'h5555_5555_5555_5555_0000_0000_0000_0000;
   localparam block_t E1 = 128'hffff_ffff_ffff_ffff_aaaa_aaaa_aaaa_aaaa;

   logic   clk;
   logic   RESET_N;
   logic   req0_valid, req0_ready, req1_valid, req1_ready;
   block_t req0_key, req0_msg, req1_key, req1_msg;
   logic   resp0_valid, resp0_ready, resp0_err, resp1_valid, resp1_ready, resp1_err;
   block_t resp0_data, resp1_data;
   logic   AES_START, AES_DONE, AES_RESET, busy;
   block_t AES_KEY, AES_MSG_ENC, AES_MSG_DEC;

   aes_dec_arbiter #(.TIMEOUT(TIMEOUT), .REL_CYCLES(REL_CYCLES)) dut (
      .clk(clk), .RESET_N(RESET_N),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_msg(req0_msg),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_msg(req1_msg),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_err(resp0_err),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_err(resp1_err),
      .AES_START(AES_START), .AES_KEY(AES_KEY), .AES_MSG_ENC(AES_MSG_ENC), .AES_DONE(AES_DONE),
      .AES_MSG_DEC(AES_MSG_DEC), .AES_RESET(AES_RESET), .busy(busy)
   );

   typedef struct {
      block_t data;
      logic   err;
   } resp_t;

   resp_t  q0[$];
   resp_t  q1[$];
   owner_t eg_q[$];
   resp_t  mon_e;

   int total = 0;
   int bad   = 0;
   int acc_cnt = 0;
   int rst_hi_cnt = 0;
   int start_hi_cnt = 0;
   int gap = 0;
   bit have_run = 0;
   bit prev_start = 0;

   int stub_delay = 3;
   bit stub_hang  = 0;
   bit stub_force = 0;
   int run_cnt    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic resp_t mk(input block_t d, input logic e);
      resp_t r;
      r.data = d;
      r.err  = e;
      return r;
   endfunction

   function automatic block_t core_f(input block_t k, input block_t c);
      return (k == FIPS_K && c == FIPS_C) ? FIPS_P : (k ^ c);
   endfunction

   // Core stub: done rises stub_delay cycles into a run and stays until start drops.
   always @(negedge clk) begin
      if (AES_START) begin
         run_cnt++;
         if (!stub_hang && run_cnt >= stub_delay) begin
            AES_DONE    = 1'b1;
            AES_MSG_DEC = core_f(AES_KEY, AES_MSG_ENC);
         end else begin
            AES_DONE    = 1'b0;
            AES_MSG_DEC = ~core_f(AES_KEY, AES_MSG_ENC);
         end
      end else begin
         run_cnt     = 0;
         AES_DONE    = stub_force;
         AES_MSG_DEC = stub_force ? 128'hdeadbeef : '0;
      end
   end

   // Monitor: grants and responses are compared against the expected queues.
   always @(negedge clk) begin
      if (resp0_valid && resp0_ready) begin
         if (q0.size() == 0) check("resp0_unexpected", 128'(1), 128'(0));
         else begin
            mon_e = q0.pop_front();
            check("resp0_data", resp0_data, mon_e.data);
            check("resp0_err", 128'(resp0_err), 128'(mon_e.err));
         end
      end
      if (resp1_valid && resp1_ready) begin
         if (q1.size() == 0) check("resp1_unexpected", 128'(1), 128'(0));
         else begin
            mon_e = q1.pop_front();
            check("resp1_data", resp1_data, mon_e.data);
            check("resp1_err", 128'(resp1_err), 128'(mon_e.err));
         end
      end
      if (req0_ready && req1_ready) check("dual_ready", 128'(1), 128'(0));
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
         acc_cnt++;
         if (eg_q.size() == 0) check("grant_unexpected", 128'(1), 128'(0));
         else check("grant_id", 128'(req1_valid && req1_ready), 128'(eg_q.pop_front()));
      end
      if (AES_RESET) rst_hi_cnt++;
      if (AES_START) start_hi_cnt++;
      if (!RESET_N) begin
         have_run = 0;
         gap      = 0;
      end else if (AES_START) begin
         // Low span = at least one RESP cycle + REL_CYCLES release + one IDLE cycle.
         if (!prev_start && have_run) check("start_gap", 128'(gap >= REL_CYCLES + 2), 128'(1));
         have_run = 1;
         gap      = 0;
      end else begin
         gap++;
      end
      prev_start = AES_START;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input owner_t id, input block_t k, input block_t m);
      int target;
      int b;
      target = acc_cnt + 1;
      b = 0;
      eg_q.push_back(id);
      if (id == 1'b0) begin
         req0_key = k; req0_msg = m; req0_valid = 1'b1;
      end else begin
         req1_key = k; req1_msg = m; req1_valid = 1'b1;
      end
      while (acc_cnt < target && b < 200) begin
         tick(1);
         b++;
      end
      if (acc_cnt < target) check("accept_timeout", 128'(1), 128'(0));
      if (id == 1'b0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
   endtask

   task automatic run_both(input owner_t first, input int n);
      int target;
      int b;
      owner_t g;
      target = acc_cnt + n;
      b = 0;
      for (int i = 0; i < n; i++) begin
         g = first ^ owner_t'(i[0]);
         eg_q.push_back(g);
         if (g == 1'b0) q0.push_back(mk(E0, 1'b0));
         else q1.push_back(mk(E1, 1'b0));
      end
      req0_key = K0; req0_msg = M0; req1_key = K1; req1_msg = M1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      while (acc_cnt < target && b < 500) begin
         tick(1);
         b++;
      end
      if (acc_cnt < target) check("contention_timeout", 128'(1), 128'(0));
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int b;
      b = 0;
      while ((busy || q0.size() != 0 || q1.size() != 0) && b < 1000) begin
         tick(1);
         b++;
      end
      if (b >= 1000) check("idle_timeout", 128'(1), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      bit v_valid, v_data, v_start, v_ready, v;
      int n;
      RESET_N = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_key = '0; req0_msg = '0; req1_key = '0; req1_msg = '0;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      AES_DONE = 1'b0; AES_MSG_DEC = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_start", 128'(AES_START), 128'(0));
      check("rst_key", AES_KEY, 128'(0));
      check("rst_msg", AES_MSG_ENC, 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_aes_reset", 128'(AES_RESET), 128'(1));
      check("rst_resp_valid", 128'({resp1_valid, resp0_valid}), 128'(0));
      check("rst_resp_data", resp0_data | resp1_data, 128'(0));
      #1 RESET_N = 1'b1;
      #1 check("aes_reset_hold", 128'(AES_RESET), 128'(1));
      @(posedge clk);
      #1 check("aes_reset_drop", 128'(AES_RESET), 128'(0));

      // Contention: 4 grants 0,1,0,1
      run_both(1'b0, 4);
      wait_idle();

      // FIPS-197 vector on requester 0
      q0.push_back(mk(FIPS_P, 1'b0));
      send(1'b0, FIPS_K, FIPS_C);
      wait_idle();

      // Backpressure on requester 1 while requester 0 waits
      resp1_ready = 1'b0;
      q1.push_back(mk(E1, 1'b0));
      send(1'b1, K1, M1);
      n = 0;
      while (!resp1_valid && n < 100) begin
         tick(1);
         n++;
      end
      check("bp_resp1_seen", 128'(resp1_valid), 128'(1));
      eg_q.push_back(1'b0);
      q0.push_back(mk(E0, 1'b0));
      req0_key = K0; req0_msg = M0; req0_valid = 1'b1;
      v_valid = 0; v_data = 0; v_start = 0; v_ready = 0;
      repeat (20) begin
         @(negedge clk);
         if (!resp1_valid) v_valid = 1;
         if (resp1_data !== E1) v_data = 1;
         if (AES_START) v_start = 1;
         if (req0_ready) v_ready = 1;
      end
      check("bp_valid_held", 128'(v_valid), 128'(0));
      check("bp_data_stable", 128'(v_data), 128'(0));
      check("bp_start_low", 128'(v_start), 128'(0));
      check("bp_no_grant", 128'(v_ready), 128'(0));
      @(posedge clk);
      #1 resp1_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req0_ready && n < 50);
      // handshake-cycle sample + REL_CYCLES release samples + first IDLE sample
      check("grant_after_release", 128'(n), 128'(REL_CYCLES + 2));
      @(posedge clk);
      #1 req0_valid = 1'b0;
      wait_idle();

      // Timeout: core never completes
      stub_hang = 1'b1;
      q0.push_back(mk('0, 1'b1));
      rst_hi_cnt = 0; start_hi_cnt = 0;
      send(1'b0, K0, M0);
      wait_idle();
      check("to_run_cycles", 128'(start_hi_cnt), 128'(TIMEOUT));
      check("to_aes_reset_pulse", 128'(rst_hi_cnt), 128'(1));
      stub_hang = 1'b0;
      q0.push_back(mk(E0, 1'b0));
      send(1'b0, K0, M0);
      wait_idle();

      // Done arrives on the timeout cycle: done wins
      stub_delay = TIMEOUT;
      rst_hi_cnt = 0; start_hi_cnt = 0;
      q0.push_back(mk(E0, 1'b0));
      send(1'b0, K0, M0);
      wait_idle();
      check("edge_run_cycles", 128'(start_hi_cnt), 128'(TIMEOUT));
      check("edge_no_abort", 128'(rst_hi_cnt), 128'(0));
      stub_delay = 3;

      // Done pulsed while idle is ignored
      stub_force = 1'b1;
      v = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp0_valid || resp1_valid || busy) v = 1;
      end
      @(posedge clk);
      #1 stub_force = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp0_valid || resp1_valid || busy) v = 1;
      end
      check("idle_done_ignored", 128'(v), 128'(0));

      // Reset mid-RUN: transaction discarded, arbiter back to req0-first
      @(posedge clk);
      #1 stub_hang = 1'b1;
      send(1'b0, K0, M0);
      tick(4);
      check("mid_busy_before", 128'(busy), 128'(1));
      RESET_N = 1'b0;
      #1;
      check("mid_start", 128'(AES_START), 128'(0));
      check("mid_busy", 128'(busy), 128'(0));
      check("mid_aes_reset", 128'(AES_RESET), 128'(1));
      check("mid_key", AES_KEY, 128'(0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 RESET_N = 1'b1;
      #1 check("mid_aes_reset_hold", 128'(AES_RESET), 128'(1));
      @(posedge clk);
      #1 check("mid_aes_reset_drop", 128'(AES_RESET), 128'(0));
      stub_hang = 1'b0;
      v = 0;
      repeat (5) begin
         @(negedge clk);
         if (resp0_valid || resp1_valid) v = 1;
      end
      check("mid_no_resp", 128'(v), 128'(0));
      @(posedge clk);
      #1 run_both(1'b0, 2);
      wait_idle();

      check("sb_q0_drained", 128'(q0.size()), 128'(0));
      check("sb_q1_drained", 128'(q1.size()), 128'(0));
      check("sb_grants_drained", 128'(eg_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
